// File: rtl/miriscv_prefetch_buffer_if.sv
// Memory-side request/response and fetch-side pop signals of the prefetch buffer.
// master = prefetch buffer, slave = memory/fetch environment.
interface miriscv_prefetch_buffer_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
) ();
  logic            instr_req_o;
  logic [XLEN-1:0] instr_addr_o;
  logic            instr_rvalid_i;
  logic [ILEN-1:0] instr_rdata_i;
  logic            pf_valid_o;
  logic [ILEN-1:0] pf_instr_o;
  logic [XLEN-1:0] pf_pc_o;
  logic [XLEN-1:0] pf_next_pc_o;
  logic            pf_ready_i;

  modport master (
    output instr_req_o, instr_addr_o, pf_valid_o, pf_instr_o, pf_pc_o, pf_next_pc_o,
    input  instr_rvalid_i, instr_rdata_i, pf_ready_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o, pf_valid_o, pf_instr_o, pf_pc_o, pf_next_pc_o,
    output instr_rvalid_i, instr_rdata_i, pf_ready_i
  );
endinterface

// File: rtl/miriscv_prefetch_buffer.sv
// Instruction prefetch queue: issues sequential word requests ahead of demand and buffers
// in-order responses with PC/next-PC; flushes on boot load or redirect.
module miriscv_prefetch_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ILEN  = 32
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic [XLEN-1:0]             boot_addr_i,
  input  logic                        boot_load_i,
  input  logic                        redirect_i,
  input  logic [XLEN-1:0]             redirect_pc_i,
  miriscv_prefetch_buffer_if.master   bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [CW-1:0]   fifo_cnt, outstanding, discard;
  logic [PW-1:0]   wptr, rptr;
  logic [XLEN-1:0] req_pc, resp_pc;

  logic [ILEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] npc_q   [DEPTH];

  logic            flush, rsp, room, req, push, pop, head_valid;
  logic [XLEN-1:0] target, target_al;

  always_comb begin
    flush      = boot_load_i | redirect_i;
    target     = boot_load_i ? boot_addr_i : redirect_pc_i;
    target_al  = target & ~XLEN'(3);
    // A response with nothing outstanding (e.g. left over from before an async reset) is ignored.
    rsp        = bus.instr_rvalid_i & (outstanding != '0);
    room       = ({1'b0, fifo_cnt} + {1'b0, outstanding}) < (CW + 1)'(DEPTH);
    req        = (state == RUN) & ~flush & room;
    head_valid = (fifo_cnt != '0);
    push       = rsp & (discard == '0) & (state == RUN) & ~flush;
    pop        = bus.pf_ready_i & head_valid & ~flush;
  end

  assign bus.instr_req_o  = req;
  assign bus.instr_addr_o = req_pc;
  assign bus.pf_valid_o   = head_valid;
  assign bus.pf_instr_o   = head_valid ? instr_q[rptr] : ILEN'(32'h13);
  assign bus.pf_pc_o      = head_valid ? pc_q[rptr]    : '0;
  assign bus.pf_next_pc_o = head_valid ? npc_q[rptr]   : '0;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state       <= IDLE;
      fifo_cnt    <= '0;
      outstanding <= '0;
      discard     <= '0;
      wptr        <= '0;
      rptr        <= '0;
      req_pc      <= '0;
      resp_pc     <= '0;
    end else if (flush) begin
      state       <= RUN;
      fifo_cnt    <= '0;
      wptr        <= '0;
      rptr        <= '0;
      req_pc      <= target_al;
      resp_pc     <= target_al;
      outstanding <= outstanding - CW'(rsp);
      discard     <= outstanding - CW'(rsp);
    end else begin
      outstanding <= outstanding + CW'(req) - CW'(rsp);
      if (req) req_pc <= req_pc + XLEN'(4);
      if (rsp && discard != '0) discard <= discard - CW'(1);
      if (push) begin
        resp_pc <= resp_pc + XLEN'(4);
        wptr    <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[wptr] <= bus.instr_rdata_i;
      pc_q[wptr]    <= resp_pc;
      npc_q[wptr]   <= resp_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i) begin
    if (arstn_i && push && !pop) assert (fifo_cnt != CW'(DEPTH));
  end
endmodule

// File: tb/tb_miriscv_prefetch_buffer.sv
// Scoreboard bench for miriscv_prefetch_buffer: a behavioural memory with configurable latency,
// an expected-PC queue filled by stimulus and drained by a negedge monitor.
module tb_miriscv_prefetch_buffer;
  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic [31:0] boot_addr_i = '0;
  logic [31:0] redirect_pc_i = '0;
  logic        boot_load_i = 1'b0;
  logic        redirect_i = 1'b0;

  always #5 clk_i = ~clk_i;

  miriscv_prefetch_buffer_if #(.XLEN(32), .ILEN(32)) bus ();

  miriscv_prefetch_buffer #(.DEPTH(4), .XLEN(32), .ILEN(32)) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .boot_addr_i   (boot_addr_i),
    .boot_load_i   (boot_load_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .bus           (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int req_count = 0;
  int pops = 0;
  int lat = 1;
  int cyc = 0;
  int last_due = 0;
  logic [31:0] exp_req_addr = '0;
  logic [31:0] exp_pc_q[$];

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  function automatic logic [31:0] mem_data(logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_stream(logic [31:0] start, int n);
    exp_pc_q.delete();
    for (int i = 0; i < n; i++) exp_pc_q.push_back(start + 32'(i * 4));
  endtask

  // Called just after a posedge; holds redirect for exactly one cycle.
  task automatic do_redirect(logic [31:0] pc);
    redirect_pc_i = pc;
    redirect_i    = 1'b1;
    exp_req_addr  = pc & ~32'h3;
    expect_stream(pc & ~32'h3, 64);
    @(posedge clk_i); #1;
    redirect_i = 1'b0;
  endtask

  // Memory response driver
  initial begin
    bus.instr_rvalid_i = 1'b0;
    bus.instr_rdata_i  = '0;
    forever begin
      @(posedge clk_i);
      cyc++;
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.instr_rvalid_i = 1'b1;
        bus.instr_rdata_i  = mem_data(mq[0].a);
        void'(mq.pop_front());
      end else begin
        bus.instr_rvalid_i = 1'b0;
        bus.instr_rdata_i  = '0;
      end
    end
  end

  // Request capture and pop monitor
  initial begin
    forever begin
      @(negedge clk_i);
      if (bus.instr_req_o) begin
        int due;
        check("req_addr", bus.instr_addr_o, exp_req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
        req_count++;
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{bus.instr_addr_o, due});
      end
      if (arstn_i && bus.pf_valid_o && bus.pf_ready_i && !boot_load_i && !redirect_i) begin
        pops++;
        if (exp_pc_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pop: got pc %h expected no entry", bus.pf_pc_o);
        end else begin
          logic [31:0] p;
          p = exp_pc_q.pop_front();
          check("pop_pc", bus.pf_pc_o, p);
          check("pop_next_pc", bus.pf_next_pc_o, p + 32'd4);
          check("pop_instr", bus.pf_instr_o, mem_data(p));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, p0, bad;
    bus.pf_ready_i = 1'b0;

    // Reset values
    repeat (2) @(negedge clk_i);
    check("rst_req", 32'(bus.instr_req_o), 32'd0);
    check("rst_valid", 32'(bus.pf_valid_o), 32'd0);
    check("rst_instr", bus.pf_instr_o, 32'h13);
    check("rst_pc", bus.pf_pc_o, 32'h0);
    check("rst_next_pc", bus.pf_next_pc_o, 32'h0);
    @(posedge clk_i); #1;
    arstn_i = 1'b1;
    repeat (3) @(posedge clk_i); #1;
    check("idle_no_req", 32'(req_count), 32'd0);

    // Boot, 1-cycle memory, first-entry latency
    bus.pf_ready_i = 1'b1;
    boot_addr_i    = 32'h8000_0000;
    boot_load_i    = 1'b1;
    exp_req_addr   = 32'h8000_0000;
    expect_stream(32'h8000_0000, 64);
    @(posedge clk_i); #1;
    boot_load_i = 1'b0;
    @(negedge clk_i);
    check("first_req", 32'(bus.instr_req_o), 32'd1);
    check("lat_valid_n0", 32'(bus.pf_valid_o), 32'd0);
    @(negedge clk_i);
    check("lat_valid_n1", 32'(bus.pf_valid_o), 32'd0);
    @(negedge clk_i);
    check("lat_valid_n2", 32'(bus.pf_valid_o), 32'd1);
    check("first_pc", bus.pf_pc_o, 32'h8000_0000);
    check("first_next_pc", bus.pf_next_pc_o, 32'h8000_0004);
    p0 = pops;
    repeat (12) @(posedge clk_i); #1;
    check("boot_pops", 32'((pops - p0) >= 10), 32'd1);

    // Back-pressure: DEPTH requests, then one per pop
    bus.pf_ready_i = 1'b0;
    do_redirect(32'h0000_1000);
    r0 = req_count;
    repeat (20) @(posedge clk_i); #1;
    check("bp_reqs", 32'(req_count - r0), 32'd4);
    check("bp_valid", 32'(bus.pf_valid_o), 32'd1);
    r0 = req_count;
    bus.pf_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.pf_ready_i = 1'b0;
    repeat (20) @(posedge clk_i); #1;
    check("bp_reqs_after_pop", 32'(req_count - r0), 32'd1);

    // 3-cycle memory: redirect with 3 requests in flight, one responding that cycle
    bus.pf_ready_i = 1'b1;
    lat = 3;
    do_redirect(32'h0000_2000);
    repeat (3) @(posedge clk_i); #1;
    do_redirect(32'h0000_0100);
    p0 = pops;
    repeat (20) @(posedge clk_i); #1;
    check("drop_pops", 32'((pops - p0) >= 4), 32'd1);

    // boot_load has priority over redirect; misaligned target
    lat = 1;
    boot_addr_i   = 32'h0000_0400;
    redirect_pc_i = 32'h0000_0200;
    boot_load_i   = 1'b1;
    redirect_i    = 1'b1;
    exp_req_addr  = 32'h0000_0400;
    expect_stream(32'h0000_0400, 64);
    @(posedge clk_i); #1;
    boot_load_i = 1'b0;
    redirect_i  = 1'b0;
    p0 = pops;
    repeat (10) @(posedge clk_i); #1;
    check("prio_pops", 32'((pops - p0) >= 6), 32'd1);
    do_redirect(32'h0000_0203);
    p0 = pops;
    repeat (10) @(posedge clk_i); #1;
    check("misalign_pops", 32'((pops - p0) >= 6), 32'd1);

    // Address wrap at 32 bits
    do_redirect(32'hFFFF_FFF8);
    p0 = pops;
    repeat (12) @(posedge clk_i); #1;
    check("wrap_pops", 32'((pops - p0) >= 8), 32'd1);

    // Async reset with 2 requests outstanding
    lat = 3;
    do_redirect(32'h0000_3000);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    arstn_i = 1'b0;
    exp_pc_q.delete();
    #1;
    check("arst_req", 32'(bus.instr_req_o), 32'd0);
    check("arst_valid", 32'(bus.pf_valid_o), 32'd0);
    check("arst_instr", bus.pf_instr_o, 32'h13);
    @(posedge clk_i); #1;
    arstn_i = 1'b1;
    bad = 0;
    r0 = req_count;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (bus.pf_valid_o || bus.instr_req_o) bad++;
    end
    check("post_arst_quiet", 32'(bad), 32'd0);
    check("post_arst_no_req", 32'(req_count - r0), 32'd0);
    @(posedge clk_i); #1;
    lat = 1;
    boot_addr_i  = 32'h8000_0000;
    boot_load_i  = 1'b1;
    exp_req_addr = 32'h8000_0000;
    expect_stream(32'h8000_0000, 64);
    @(posedge clk_i); #1;
    boot_load_i = 1'b0;
    p0 = pops;
    repeat (12) @(posedge clk_i); #1;
    check("reboot_pops", 32'((pops - p0) >= 8), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
